// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read ports, both write ports, reservation and scoreboard status.
// The master modport drives requests; the slave modport is the register file side.
interface reg_file_sb_if #(
  parameter int unsigned BITS = 16,
  parameter int unsigned N    = 3
);
  logic [N-1:0]      RA1;
  logic [N-1:0]      RA2;
  logic [BITS-1:0]   RD1;
  logic [BITS-1:0]   RD2;
  logic              RB1;
  logic              RB2;
  logic [N-1:0]      WA3;
  logic [BITS-1:0]   WD3;
  logic              WE3;
  logic [N-1:0]      WA4;
  logic [BITS-1:0]   WD4;
  logic              WE4;
  logic [N-1:0]      RSV_A;
  logic              RSV_EN;
  logic              RSV_GNT;
  logic [(1<<N)-1:0] PEND;
  logic              ERR;

  modport master (
    output RA1, RA2, WA3, WD3, WE3, WA4, WD4, WE4, RSV_A, RSV_EN,
    input  RD1, RD2, RB1, RB2, RSV_GNT, PEND, ERR
  );

  modport slave (
    input  RA1, RA2, WA3, WD3, WE3, WA4, WD4, WE4, RSV_A, RSV_EN,
    output RD1, RD2, RB1, RB2, RSV_GNT, PEND, ERR
  );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read, two-write register file with a per-register pending scoreboard and sticky ERR.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_sb #(
  parameter int unsigned BITS = 16,
  parameter int unsigned N    = 3
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);
  localparam int unsigned Depth = 1 << N;

  logic [BITS-1:0]  mem_q [Depth];
  logic [BITS-1:0]  mem_d [Depth];
  logic [Depth-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic             rsv_gnt;
  logic             wr4_hits_rsv;
  logic             wr3_superseded;

  assign wr4_hits_rsv   = bus.WE4 && (bus.WA4 == bus.RSV_A);
  assign rsv_gnt        = bus.RSV_EN && (!pend_q[bus.RSV_A] || wr4_hits_rsv);
  // A port-3 write overridden by a same-address port-4 completion never reaches the array.
  assign wr3_superseded = bus.WE4 && (bus.WA4 == bus.WA3);

  always_comb begin
    mem_d = mem_q;
    if (bus.WE3) mem_d[bus.WA3] = bus.WD3;
    if (bus.WE4) mem_d[bus.WA4] = bus.WD4;
  end

  // Reservation set is applied after the port-4 clear so it wins on the same address.
  always_comb begin
    pend_d = pend_q;
    if (bus.WE4) pend_d[bus.WA4] = 1'b0;
    if (rsv_gnt) pend_d[bus.RSV_A] = 1'b1;
  end

  always_comb begin
    err_d = err_q;
    if (bus.WE3 && pend_q[bus.WA3] && !wr3_superseded) err_d = 1'b1;
    if (bus.WE4 && !pend_q[bus.WA4])                  err_d = 1'b1;
    if (bus.RSV_EN && !rsv_gnt)                       err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    if (bus.WE4 && (bus.WA4 == bus.RA1))      bus.RD1 = bus.WD4;
    else if (bus.WE3 && (bus.WA3 == bus.RA1)) bus.RD1 = bus.WD3;
    else                                      bus.RD1 = mem_q[bus.RA1];

    if (bus.WE4 && (bus.WA4 == bus.RA2))      bus.RD2 = bus.WD4;
    else if (bus.WE3 && (bus.WA3 == bus.RA2)) bus.RD2 = bus.WD3;
    else                                      bus.RD2 = mem_q[bus.RA2];

    bus.RB1 = pend_q[bus.RA1];
    if (bus.WE4 && (bus.WA4 == bus.RA1)) bus.RB1 = rsv_gnt && (bus.RSV_A == bus.RA1);
    bus.RB2 = pend_q[bus.RA2];
    if (bus.WE4 && (bus.WA4 == bus.RA2)) bus.RB2 = rsv_gnt && (bus.RSV_A == bus.RA2);
  end
`else
  always_comb begin
    bus.RD1 = mem_q[bus.RA1];
    bus.RD2 = mem_q[bus.RA2];
    bus.RB1 = pend_q[bus.RA1];
    bus.RB2 = pend_q[bus.RA2];
  end
`endif

  assign bus.RSV_GNT = rsv_gnt;
  assign bus.PEND    = pend_q;
  assign bus.ERR     = err_q;
endmodule
